aes_data_stager: RTL and testbench
==================================

Name: aes_data_stager

Overview:
- Word-to-block staging buffer that sits directly upstream and downstream of aes_cipher_core_wrapper.
- Input side: collects four 32-bit words from the register/bus side into one 128-bit block and offers it on the core's crypt request handshake.
- Output side: captures the 128-bit crypt result and streams it back as four 32-bit words, in order.
- The input buffer refills while the core runs; at most one block is outstanding in the core.

Parameters:
- WordWidth, 32, width of bus-side words; only 32 is supported.
- ByteSwap, 0, when 1 the byte order within each word is reversed on both input and output.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort; flushes both buffers
- in_word_valid_i  in  1  word write request
- in_word_ready_o  out  1  write accepted this cycle
- in_word_idx_i  in  2  word slot
- in_word_i  in  32  word data
- crypt_valid_o  out  1  block offered to the core
- crypt_ack_i  in  1  core accepted the block
- crypt_data_o  out  128  block; word i occupies bits [32i+:32]
- res_valid_i  in  1  core result valid
- res_ack_o  out  1  result consumed
- res_data_i  in  128  result block; same word mapping as crypt_data_o
- out_word_valid_o  out  1  output word available
- out_word_ready_i  in  1  consumer takes the word
- out_word_idx_o  out  2  slot index of out_word_o
- out_word_o  out  32  output word
- pending_o  out  1  a block is in the core and its result has not yet been consumed

Behaviour:
- Reset values: all outputs 0; both buffers 0; written-mask 0; in-FSM IN_FILL; out-FSM OUT_IDLE; pending 0; discard 0.
- Handshake rule: a transfer occurs on a cycle where valid and ready/ack are both high. Once crypt_valid_o or out_word_valid_o is raised, it and its data stay stable until the transfer, except on clear_i.

Input FSM:
- IN_FILL: in_word_ready_o = 1. An accepted write stores the (optionally byte-swapped) word into slot in_word_idx_i and sets that mask bit. Rewriting a slot overwrites it.
- IN_FILL -> IN_PRESENT when the mask becomes 4'b1111. crypt_valid_o rises the cycle after the last write, so latency is 1 cycle.
- IN_PRESENT: in_word_ready_o = 0. crypt_valid_o = !pending.
- On crypt transfer: mask cleared, pending set, state returns to IN_FILL. The next write is accepted the following cycle.

Output FSM:
- OUT_IDLE: res_ack_o = 1. A result transfer captures res_data_i, clears pending, and moves to OUT_DRAIN with word counter 0.
- res_valid_i while pending = 0 and discard = 0: res_ack_o is still 1 and the data is dropped. This is a protocol error; it has no effect on state.
- OUT_DRAIN: res_ack_o = 0. out_word_valid_o = 1, out_word_idx_o = counter, out_word_o = slot[counter] (byte-swapped if ByteSwap).
- Each out transfer increments the 2-bit counter. The transfer of word 3 wraps the counter to 0 and returns to OUT_IDLE; a new result can be acked the next cycle.
- Latency from result capture to the first output word: 1 cycle.

pending_o: set on the crypt transfer; cleared on result capture or on a discarded result.

Simultaneous events:
- A crypt transfer and a result capture in the same cycle cannot occur, because crypt_valid_o requires pending = 0.
- A write and clear_i in the same cycle: clear_i wins and the write is dropped, even though in_word_ready_o may be high.

clear_i (one cycle):
- Mask, both buffers, and counter go to 0. Both FSMs return to idle; crypt_valid_o and out_word_valid_o drop the next cycle.
- If pending = 1, discard is set, pending stays 1, and crypt_valid_o stays low. The next result is acked and dropped, which clears discard and pending.
- clear_i has no effect on a result transfer already completing that cycle.

Reset asserted mid-operation: immediate return to reset values. An in-flight core result after reset is handled by the protocol-error rule.

Decomposition:
- aes_pkg additions:
  - stager_in_e {IN_FILL, IN_PRESENT}
  - stager_out_e {OUT_IDLE, OUT_DRAIN}
  - localparam NumStateWords = 4
  - a byte-swap function aes_bswap32
- One sub-module, aes_word_unpacker: 128-bit output register, 2-bit counter and out handshake (the OUT_DRAIN logic).

Test Plan:
- Write idx 0..3 = 00112233, 44556677, 8899aabb, ccddeeff (ByteSwap=0) -> the next cycle crypt_valid_o=1 and crypt_data_o = ccddeeff_8899aabb_44556677_00112233. Hold crypt_ack_i low for 5 cycles -> data stable; ack -> pending_o=1 and in_word_ready_o=1 the next cycle.
- Writes in order 3,1,1(=deadbeef),0,2 -> present only after the fifth write; slot1 = deadbeef.
- Drive res_data_i = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a with out_word_ready_i toggling 1,0,1,... -> words 70b4c55a, d8cdb780, 6a7b0430, 69c4e0d8 with idx 0..3 in order; res_ack_o held low until word 3 is taken.
- Second block fully written while the first is pending -> crypt_valid_o stays 0 until the result is captured, then rises the next cycle.
- clear_i while pending -> the next res_valid_i is acked, no out_word_valid_o, pending_o=0 afterward; a fresh block then works normally.
- rst_ni asserted during OUT_DRAIN word 2 -> all outputs 0 immediately; ByteSwap=1 run: input 00112233 appears as 33221100 in crypt_data_o[31:0].

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES data staging path.
`default_nettype none

package aes_pkg;

  localparam int NumStateWords = 4;

  typedef enum logic [0:0] {
    IN_FILL    = 1'b0,
    IN_PRESENT = 1'b1
  } stager_in_e;

  typedef enum logic [0:0] {
    OUT_IDLE  = 1'b0,
    OUT_DRAIN = 1'b1
  } stager_out_e;

  function automatic logic [31:0] aes_bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_word_unpacker.sv
// Holds one 128-bit cipher result and streams it out as four words, slot 0 first.
`default_nettype none

module aes_word_unpacker
  import aes_pkg::*;
#(
  parameter int WordWidth = 32,
  parameter bit ByteSwap  = 1'b0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               load_i,
  input  logic [NumStateWords*WordWidth-1:0] load_data_i,
  output logic                               res_ack_o,
  output logic                               out_word_valid_o,
  input  logic                               out_word_ready_i,
  output logic [1:0]                         out_word_idx_o,
  output logic [WordWidth-1:0]               out_word_o
);

  stager_out_e                        state_q;
  logic [NumStateWords*WordWidth-1:0] buf_q;
  logic [1:0]                         cnt_q;
  logic                               ack_q;
  logic [WordWidth-1:0]               w_slot;

  // A load always wins over clear: a result already completing is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OUT_IDLE;
      buf_q   <= '0;
      cnt_q   <= 2'd0;
      ack_q   <= 1'b0;
    end else if (load_i) begin
      state_q <= OUT_DRAIN;
      buf_q   <= load_data_i;
      cnt_q   <= 2'd0;
      ack_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= OUT_IDLE;
      buf_q   <= '0;
      cnt_q   <= 2'd0;
      ack_q   <= 1'b1;
    end else if (state_q == OUT_IDLE) begin
      ack_q <= 1'b1;
    end else if (out_word_ready_i) begin
      cnt_q <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        state_q <= OUT_IDLE;
        ack_q   <= 1'b1;
      end
    end
  end

  assign w_slot           = buf_q[{cnt_q, 5'd0} +: WordWidth];
  assign out_word_o       = ByteSwap ? aes_bswap32(w_slot) : w_slot;
  assign out_word_idx_o   = cnt_q;
  assign out_word_valid_o = (state_q == OUT_DRAIN);
  assign res_ack_o        = ack_q;

endmodule

`default_nettype wire

// File: rtl/aes_data_stager.sv
// Word-to-block staging buffer around the AES cipher core: packs four input
// words into a crypt request and unpacks the result back into four words.
`default_nettype none

module aes_data_stager
  import aes_pkg::*;
#(
  parameter int WordWidth = 32,
  parameter bit ByteSwap  = 1'b0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               in_word_valid_i,
  output logic                               in_word_ready_o,
  input  logic [1:0]                         in_word_idx_i,
  input  logic [WordWidth-1:0]               in_word_i,
  output logic                               crypt_valid_o,
  input  logic                               crypt_ack_i,
  output logic [NumStateWords*WordWidth-1:0] crypt_data_o,
  input  logic                               res_valid_i,
  output logic                               res_ack_o,
  input  logic [NumStateWords*WordWidth-1:0] res_data_i,
  output logic                               out_word_valid_o,
  input  logic                               out_word_ready_i,
  output logic [1:0]                         out_word_idx_o,
  output logic [WordWidth-1:0]               out_word_o,
  output logic                               pending_o
);

  stager_in_e                         in_state_q;
  logic [NumStateWords-1:0]           mask_q;
  logic [NumStateWords*WordWidth-1:0] in_buf_q;
  logic                               in_ready_q;
  logic                               crypt_valid_q;
  logic                               pending_q, pending_d;
  logic                               discard_q, discard_d;

  logic                               w_res_ack;
  logic                               w_write;
  logic                               w_crypt_xfer;
  logic                               w_res_xfer;
  logic                               w_res_done;
  logic                               w_capture;
  logic [WordWidth-1:0]               w_word;
  logic [NumStateWords-1:0]           w_mask_next;

  assign w_write      = in_word_valid_i && in_ready_q && !clear_i;
  assign w_crypt_xfer = crypt_valid_q && crypt_ack_i;
  assign w_res_xfer   = res_valid_i && w_res_ack;
  // Any result accepted while a block is outstanding retires it; only a
  // non-discarded one is forwarded to the unpacker.
  assign w_res_done   = w_res_xfer && pending_q;
  assign w_capture    = w_res_done && !discard_q;
  assign w_word       = ByteSwap ? aes_bswap32(in_word_i) : in_word_i;
  assign w_mask_next  = mask_q | (4'b0001 << in_word_idx_i);

  always_comb begin
    pending_d = pending_q;
    discard_d = discard_q;
    if (w_res_done) begin
      pending_d = 1'b0;
      discard_d = 1'b0;
    end
    if (w_crypt_xfer) begin
      pending_d = 1'b1;
    end
    if (clear_i && pending_d) begin
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_state_q    <= IN_FILL;
      mask_q        <= '0;
      in_buf_q      <= '0;
      in_ready_q    <= 1'b0;
      crypt_valid_q <= 1'b0;
      pending_q     <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      discard_q <= discard_d;
      if (clear_i) begin
        in_state_q    <= IN_FILL;
        mask_q        <= '0;
        in_buf_q      <= '0;
        in_ready_q    <= 1'b1;
        crypt_valid_q <= 1'b0;
      end else if (in_state_q == IN_FILL) begin
        in_ready_q <= 1'b1;
        if (w_write) begin
          in_buf_q[{in_word_idx_i, 5'd0} +: WordWidth] <= w_word;
          mask_q <= w_mask_next;
          if (&w_mask_next) begin
            in_state_q    <= IN_PRESENT;
            in_ready_q    <= 1'b0;
            crypt_valid_q <= !pending_d;
          end
        end
      end else if (w_crypt_xfer) begin
        in_state_q    <= IN_FILL;
        mask_q        <= '0;
        in_ready_q    <= 1'b1;
        crypt_valid_q <= 1'b0;
      end else begin
        // Holds off while the previous block is still in the core.
        crypt_valid_q <= !pending_d;
      end
    end
  end

  aes_word_unpacker #(
    .WordWidth (WordWidth),
    .ByteSwap  (ByteSwap)
  ) u_unpacker (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .load_i           (w_capture),
    .load_data_i      (res_data_i),
    .res_ack_o        (w_res_ack),
    .out_word_valid_o (out_word_valid_o),
    .out_word_ready_i (out_word_ready_i),
    .out_word_idx_o   (out_word_idx_o),
    .out_word_o       (out_word_o)
  );

  assign in_word_ready_o = in_ready_q;
  assign crypt_valid_o   = crypt_valid_q;
  assign crypt_data_o    = in_buf_q;
  assign res_ack_o       = w_res_ack;
  assign pending_o       = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_data_stager.sv
// Self-checking bench for aes_data_stager: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
`default_nettype none

module tb_aes_data_stager;

  logic         clk, rst_n;
  logic         clear, in_valid, crypt_ack, res_valid, out_ready;
  logic [1:0]   in_idx;
  logic [31:0]  in_word;
  logic [127:0] res_data;
  logic         in_ready, crypt_valid, res_ack, out_valid, pending;
  logic [127:0] crypt_data;
  logic [1:0]   out_idx;
  logic [31:0]  out_word;

  logic         b_clear, b_in_valid, b_crypt_ack, b_res_valid, b_out_ready;
  logic [1:0]   b_in_idx;
  logic [31:0]  b_in_word;
  logic [127:0] b_res_data;
  logic         b_in_ready, b_crypt_valid, b_res_ack, b_out_valid, b_pending;
  logic [127:0] b_crypt_data;
  logic [1:0]   b_out_idx;
  logic [31:0]  b_out_word;

  int checks = 0;
  int errors = 0;

  aes_data_stager #(.WordWidth(32), .ByteSwap(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_word_valid_i(in_valid), .in_word_ready_o(in_ready),
    .in_word_idx_i(in_idx), .in_word_i(in_word),
    .crypt_valid_o(crypt_valid), .crypt_ack_i(crypt_ack), .crypt_data_o(crypt_data),
    .res_valid_i(res_valid), .res_ack_o(res_ack), .res_data_i(res_data),
    .out_word_valid_o(out_valid), .out_word_ready_i(out_ready),
    .out_word_idx_o(out_idx), .out_word_o(out_word), .pending_o(pending)
  );

  aes_data_stager #(.WordWidth(32), .ByteSwap(1'b1)) dut_bs (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
    .in_word_valid_i(b_in_valid), .in_word_ready_o(b_in_ready),
    .in_word_idx_i(b_in_idx), .in_word_i(b_in_word),
    .crypt_valid_o(b_crypt_valid), .crypt_ack_i(b_crypt_ack), .crypt_data_o(b_crypt_data),
    .res_valid_i(b_res_valid), .res_ack_o(b_res_ack), .res_data_i(b_res_data),
    .out_word_valid_o(b_out_valid), .out_word_ready_i(b_out_ready),
    .out_word_idx_o(b_out_idx), .out_word_o(b_out_word), .pending_o(b_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit        m_rdy, m_cv, m_ack, m_drain, m_pend, m_disc, m_present;
  bit        m_mask[4];
  bit [31:0] m_slot[4];
  bit [31:0] m_obuf[4];
  int        m_cnt;

  task automatic model_reset();
    m_rdy = 0; m_cv = 0; m_ack = 0; m_drain = 0; m_pend = 0; m_disc = 0;
    m_present = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_mask[i] = 0; m_slot[i] = '0; m_obuf[i] = '0;
    end
  endtask

  task automatic model_edge();
    bit wr, cx, rx, ox, cap, old_p, full;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr = in_valid && m_rdy && !clear;
    cx = m_cv && crypt_ack;
    rx = res_valid && m_ack;
    ox = m_drain && out_ready;
    if (clear) begin
      m_present = 0;
      for (int i = 0; i < 4; i++) begin m_slot[i] = '0; m_mask[i] = 0; end
    end else if (cx) begin
      m_present = 0;
      for (int i = 0; i < 4; i++) m_mask[i] = 0;
    end else if (wr) begin
      m_slot[in_idx] = in_word;
      m_mask[in_idx] = 1;
      full = 1;
      for (int i = 0; i < 4; i++) full = full && m_mask[i];
      if (full) m_present = 1;
    end
    old_p = m_pend;
    cap = 0;
    if (rx && old_p) begin
      cap = !m_disc;
      m_disc = 0;
      m_pend = 0;
    end
    if (cx) m_pend = 1;
    if (clear && m_pend) m_disc = 1;
    if (cap) begin
      for (int i = 0; i < 4; i++) m_obuf[i] = res_data[32*i +: 32];
      m_drain = 1; m_cnt = 0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) m_obuf[i] = '0;
      m_drain = 0; m_cnt = 0;
    end else if (ox) begin
      if (m_cnt == 3) begin m_drain = 0; m_cnt = 0; end
      else m_cnt = m_cnt + 1;
    end
    m_rdy = !m_present;
    m_cv  = m_present && !m_pend;
    m_ack = !m_drain;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("in_ready", in_ready, m_rdy);
    chk("crypt_valid", crypt_valid, m_cv);
    chk("crypt_data", crypt_data, {m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
    chk("res_ack", res_ack, m_ack);
    chk("out_valid", out_valid, m_drain);
    chk("out_idx", out_idx, m_cnt[1:0]);
    chk("out_word", out_word, m_obuf[m_cnt]);
    chk("pending", pending, m_pend);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic write(input logic [1:0] idx, input logic [31:0] w);
    in_valid = 1; in_idx = idx; in_word = w;
    step();
    in_valid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_crypt_valid"}, crypt_valid, 0);
    chk({tag, "_crypt_data"}, crypt_data, 0);
    chk({tag, "_res_ack"}, res_ack, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_out_word"}, out_word, 0);
    chk({tag, "_pending"}, pending, 0);
  endtask

  logic [31:0] exp_w[4];
  logic [31:0] vec_w[4];
  int          got;

  initial begin
    rst_n = 0; clear = 0; in_valid = 0; in_idx = 0; in_word = 0;
    crypt_ack = 0; res_valid = 0; res_data = 0; out_ready = 0;
    b_clear = 0; b_in_valid = 0; b_in_idx = 0; b_in_word = 0;
    b_crypt_ack = 0; b_res_valid = 0; b_res_data = 0; b_out_ready = 0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    step();
    chk("ready_after_reset", in_ready, 1);

    // Basic block assembly and stable presentation.
    vec_w[0] = 32'h00112233; vec_w[1] = 32'h44556677;
    vec_w[2] = 32'h8899aabb; vec_w[3] = 32'hccddeeff;
    for (int i = 0; i < 4; i++) write(i[1:0], vec_w[i]);
    chk("present_valid", crypt_valid, 1);
    chk("present_data", crypt_data, 128'hccddeeff_8899aabb_44556677_00112233);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", crypt_data, 128'hccddeeff_8899aabb_44556677_00112233);
      chk("hold_valid", crypt_valid, 1);
    end
    crypt_ack = 1; step(); crypt_ack = 0;
    chk("ack_pending", pending, 1);
    chk("ack_ready", in_ready, 1);

    // Out-of-order writes with an overwrite; block 1 still pending.
    write(2'd3, 32'h33333333);
    write(2'd1, 32'h11111111);
    write(2'd1, 32'hdeadbeef);
    write(2'd0, 32'h00000000);
    chk("partial_ready", in_ready, 1);
    write(2'd2, 32'h22222222);
    chk("full_ready", in_ready, 0);
    chk("blocked_valid", crypt_valid, 0);
    chk("slot1_overwrite", crypt_data[63:32], 32'hdeadbeef);

    // Result capture and paced drain.
    res_valid = 1; res_data = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    step(); res_valid = 0;
    chk("cap_pending", pending, 0);
    chk("cap_out_valid", out_valid, 1);
    chk("second_valid", crypt_valid, 1);
    exp_w[0] = 32'h70b4c55a; exp_w[1] = 32'hd8cdb780;
    exp_w[2] = 32'h6a7b0430; exp_w[3] = 32'h69c4e0d8;
    got = 0;
    for (int c = 0; c < 16 && got < 4; c++) begin
      out_ready = (c % 2 == 0);
      if (out_valid) chk("drain_res_ack", res_ack, 0);
      if (out_valid && out_ready) begin
        chk("drain_idx", out_idx, got[1:0]);
        chk("drain_word", out_word, exp_w[got]);
        got++;
      end
      step();
    end
    out_ready = 0;
    chk("drain_count", got, 4);
    chk("drain_done_ack", res_ack, 1);
    chk("drain_done_valid", out_valid, 0);

    // Abort while a block is in the core.
    crypt_ack = 1; step(); crypt_ack = 0;
    chk("abort_pre_pending", pending, 1);
    clear = 1; step(); clear = 0;
    chk("abort_pending", pending, 1);
    chk("abort_valid", crypt_valid, 0);
    res_valid = 1; res_data = {$urandom, $urandom, $urandom, $urandom};
    step(); res_valid = 0;
    chk("discard_out_valid", out_valid, 0);
    chk("discard_pending", pending, 0);

    // Fresh block, then reset mid-drain.
    for (int i = 0; i < 4; i++) write(i[1:0], $urandom);
    chk("fresh_valid", crypt_valid, 1);
    crypt_ack = 1; step(); crypt_ack = 0;
    res_valid = 1; res_data = {$urandom, $urandom, $urandom, $urandom};
    step(); res_valid = 0;
    chk("fresh_out_valid", out_valid, 1);
    out_ready = 1; step(); step(); out_ready = 0;
    chk("mid_drain_idx", out_idx, 2);
    rst_n = 0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    step();
    rst_n = 1;
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 799) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      in_valid  = $urandom_range(0, 1);
      in_idx    = 2'($urandom_range(0, 3));
      in_word   = $urandom;
      crypt_ack = ($urandom_range(0, 2) == 0);
      res_valid = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      res_data  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = $urandom_range(0, 1);
      step();
    end
    rst_n = 1; clear = 0; in_valid = 0; crypt_ack = 0; res_valid = 0; out_ready = 0;
    step(); step();

    // Byte-swapped instance.
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1; b_in_idx = i[1:0]; b_in_word = vec_w[i];
      step();
    end
    b_in_valid = 0;
    chk("bs_valid", b_crypt_valid, 1);
    chk("bs_word0", b_crypt_data[31:0], 32'h33221100);
    chk("bs_word3", b_crypt_data[127:96], 32'hffeeddcc);
    b_crypt_ack = 1; step(); b_crypt_ack = 0;
    b_res_valid = 1; b_res_data = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    step(); b_res_valid = 0;
    chk("bs_out_valid", b_out_valid, 1);
    chk("bs_out_word0", b_out_word, 32'h5ac5b470);
    b_out_ready = 1; step(); b_out_ready = 0;
    chk("bs_out_idx1", b_out_idx, 1);
    chk("bs_out_word1", b_out_word, 32'h80b7cdd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
